// File: rtl/d_sram_bridge_pkg.sv
// Shared definitions for the data-SRAM to sram-like bridge.
// Holds bus widths, FSM state encodings, transfer size codes and the
// latched request payload.
package d_sram_bridge_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned WEN_W  = 4;

  // Bridge FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } bridgeState_t;

  // sram-like transfer size codes
  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } sizeCode_t;

  // Request fields captured when an access starts
  typedef struct packed {
    logic              wr;
    sizeCode_t         size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } sramReq_t;

endpackage

// File: rtl/d_sram_bridge_wen_decode.sv
// wen_decode: byte-strobe to transfer size / low address decode.
// Ports:
//   wen    - CPU byte write strobes (0 = read)
//   wr     - 1 for any non-zero strobe pattern
//   size   - BYTE / HALF / WORD transfer size
//   offset - replacement for addr[1:0] (0 for word transfers)
module wen_decode
  import d_sram_bridge_pkg::*;
(
  input  logic [WEN_W-1:0] wen,
  output logic             wr,
  output sizeCode_t        size,
  output logic [1:0]       offset
);

  // Irregular strobe patterns fall through to a word write
  always_comb begin
    wr     = 1'b1;
    size   = SIZE_WORD;
    offset = 2'd0;
    case (wen)
      4'b0000: wr = 1'b0;
      4'b0001: begin size = SIZE_BYTE; offset = 2'd0; end
      4'b0010: begin size = SIZE_BYTE; offset = 2'd1; end
      4'b0100: begin size = SIZE_BYTE; offset = 2'd2; end
      4'b1000: begin size = SIZE_BYTE; offset = 2'd3; end
      4'b0011: begin size = SIZE_HALF; offset = 2'd0; end
      4'b1100: begin size = SIZE_HALF; offset = 2'd2; end
      default: ;
    endcase
  end

endmodule

// File: rtl/d_sram_bridge.sv
// d_sram_bridge: converts the CPU M-stage data_sram port into a single
// sram-like request/response handshake, stalling the pipeline meanwhile.
// Ports:
//   clk, rst               - clock, synchronous active-low reset
//   data_sram_*            - CPU-side access (en, wen, addr, wdata, rdata)
//   d_stall                - combinational stall request to the CPU
//   longest_stall          - CPU aggregate stall; holds the bridge in DONE
//   except_cancel          - suppresses an access that has not started yet
//   req/wr/size/addr/wdata - memory-side request
//   addr_ok/data_ok/rdata  - memory-side acceptance and response
module d_sram_bridge
  import d_sram_bridge_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              data_sram_en,
  input  logic [WEN_W-1:0]  data_sram_wen,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [DATA_W-1:0] data_sram_wdata,
  output logic [DATA_W-1:0] data_sram_rdata,
  output logic              d_stall,
  input  logic              longest_stall,
  input  logic              except_cancel,
  output logic              req,
  output logic              wr,
  output logic [1:0]        size,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic              addr_ok,
  input  logic              data_ok,
  input  logic [DATA_W-1:0] rdata
);

  bridgeState_t state;
  sramReq_t     reqReg;
  logic         decWr;
  sizeCode_t    decSize;
  logic [1:0]   decOffset;
  logic         startAccess;
  logic         unusedAddrBits;

  wen_decode uWenDecode (
    .wen    (data_sram_wen),
    .wr     (decWr),
    .size   (decSize),
    .offset (decOffset)
  );

  assign startAccess    = data_sram_en & ~except_cancel;
  // Low address bits are always replaced by the decoded offset
  assign unusedAddrBits = ^data_sram_addr[1:0];

  // Handshake FSM with registered request fields and read data
  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      req             <= 1'b0;
      reqReg.wr       <= 1'b0;
      reqReg.size     <= SIZE_BYTE;
      reqReg.addr     <= '0;
      reqReg.wdata    <= '0;
      data_sram_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (startAccess) begin
            state        <= ADDR;
            req          <= 1'b1;
            reqReg.wr    <= decWr;
            reqReg.size  <= decSize;
            reqReg.addr  <= {data_sram_addr[ADDR_W-1:2], decOffset};
            reqReg.wdata <= data_sram_wdata;
          end
        end
        ADDR: begin
          if (addr_ok) begin
            state <= DATA;
            req   <= 1'b0;
          end
        end
        DATA: begin
          if (data_ok) begin
            state <= DONE;
            if (!reqReg.wr) data_sram_rdata <= rdata;
          end
        end
        DONE: begin
          // A stalled CPU keeps presenting the same access; do not reissue it
          if (!longest_stall) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign wr    = reqReg.wr;
  assign size  = reqReg.size;
  assign addr  = reqReg.addr;
  assign wdata = reqReg.wdata;

  // Stall must rise in the same cycle the CPU presents the access
  assign d_stall = rst & (((state == IDLE) & startAccess) |
                          (state == ADDR) | (state == DATA));

endmodule

// File: tb/tb_d_sram_bridge.sv
// Self-checking bench for d_sram_bridge: directed scenarios with literal
// expectations plus a randomized run checked every cycle against a
// transaction-level model.
module tb_d_sram_bridge;

  logic        clk;
  logic        rst;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        d_stall;
  logic        longest_stall;
  logic        except_cancel;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  int checks = 0;
  int passes = 0;

  // Transaction model: one outstanding access at a time
  bit          modelValid = 0;
  bit          mBusy      = 0;  // access issued, response not yet seen
  bit          mGotAddr   = 0;  // address accepted by memory
  bit          mHeld      = 0;  // completed, waiting for the CPU to release
  logic        mWr        = 0;
  logic [1:0]  mSize      = 0;
  logic [31:0] mAddr      = 0;
  logic [31:0] mWdata     = 0;
  logic [31:0] mRdata     = 0;

  d_sram_bridge dut (
    .clk             (clk),
    .rst             (rst),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .d_stall         (d_stall),
    .longest_stall   (longest_stall),
    .except_cancel   (except_cancel),
    .req             (req),
    .wr              (wr),
    .size            (size),
    .addr            (addr),
    .wdata           (wdata),
    .addr_ok         (addr_ok),
    .data_ok         (data_ok),
    .rdata           (rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endfunction

  // {wr, size, offset} derived from the strobe rules
  function automatic logic [4:0] expDecode(input logic [3:0] w);
    logic [4:0] r;
    r = {1'b1, 2'd2, 2'd0};
    if (w == 4'b0000) r = {1'b0, 2'd2, 2'd0};
    else if ($countones(w) == 1) begin
      for (int i = 0; i < 4; i++) if (w[i]) r = {1'b1, 2'd0, 2'(i)};
    end
    else if (w == 4'b0011) r = {1'b1, 2'd1, 2'd0};
    else if (w == 4'b1100) r = {1'b1, 2'd1, 2'd2};
    return r;
  endfunction

  task automatic modelStep();
    logic [4:0] d;
    if (!rst) begin
      mBusy = 0; mGotAddr = 0; mHeld = 0;
      mWr = 0; mSize = 0; mAddr = 0; mWdata = 0; mRdata = 0;
    end else if (mHeld) begin
      if (!longest_stall) mHeld = 0;
    end else if (!mBusy) begin
      if (data_sram_en && !except_cancel) begin
        d = expDecode(data_sram_wen);
        mWr = d[4]; mSize = d[3:2];
        mAddr = {data_sram_addr[31:2], d[1:0]};
        mWdata = data_sram_wdata;
        mBusy = 1; mGotAddr = 0;
      end
    end else if (!mGotAddr) begin
      if (addr_ok) mGotAddr = 1;
    end else if (data_ok) begin
      mBusy = 0; mHeld = 1;
      if (!mWr) mRdata = rdata;
    end
    modelValid = 1;
  endtask

  // Inputs change 1 time unit after each rising edge
  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic quietInputs();
    data_sram_en = 0; data_sram_wen = 0; data_sram_addr = 0; data_sram_wdata = 0;
    except_cancel = 0; longest_stall = 0; addr_ok = 0; data_ok = 0; rdata = 0;
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (modelValid) begin
      chk("m_req", 32'(req), 32'(mBusy && !mGotAddr));
      chk("m_stall", 32'(d_stall),
          32'(rst && ((!mBusy && !mHeld && data_sram_en && !except_cancel) || mBusy)));
      chk("m_wr", 32'(wr), 32'(mWr));
      chk("m_size", 32'(size), 32'(mSize));
      chk("m_addr", addr, mAddr);
      chk("m_wdata", wdata, mWdata);
      chk("m_rdata", data_sram_rdata, mRdata);
    end
  end

  initial begin
    rst = 0;
    quietInputs();
    tick(); tick();
    rst = 1;
    settle();
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_rdata", data_sram_rdata, 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_stall", 32'(d_stall), 32'd0);

    // Fast read: en in cycle 0, data valid in cycle 3
    data_sram_en = 1; data_sram_wen = 4'b0000; data_sram_addr = 32'h1000_0006;
    settle();
    chk("rd_c0_stall", 32'(d_stall), 32'd1);
    chk("rd_c0_req", 32'(req), 32'd0);
    tick();
    addr_ok = 1;
    settle();
    chk("rd_c1_req", 32'(req), 32'd1);
    chk("rd_c1_addr", addr, 32'h1000_0004);
    chk("rd_c1_size", 32'(size), 32'd2);
    chk("rd_c1_wr", 32'(wr), 32'd0);
    chk("rd_c1_stall", 32'(d_stall), 32'd1);
    tick();
    addr_ok = 0; data_ok = 1; rdata = 32'hDEAD_BEEF;
    settle();
    chk("rd_c2_req", 32'(req), 32'd0);
    chk("rd_c2_stall", 32'(d_stall), 32'd1);
    tick();
    data_ok = 0; rdata = 0;
    settle();
    chk("rd_c3_stall", 32'(d_stall), 32'd0);
    chk("rd_c3_rdata", data_sram_rdata, 32'hDEAD_BEEF);
    data_sram_en = 0;
    tick();

    // Byte write with slow address acceptance, then a stalled pipeline
    data_sram_en = 1; data_sram_wen = 4'b0100; data_sram_addr = 32'h20;
    data_sram_wdata = 32'h00AB_0000;
    tick();
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("bw_req", 32'(req), 32'd1);
      chk("bw_wr", 32'(wr), 32'd1);
      chk("bw_size", 32'(size), 32'd0);
      chk("bw_addr", addr, 32'h22);
      chk("bw_wdata", wdata, 32'h00AB_0000);
      chk("bw_stall", 32'(d_stall), 32'd1);
      tick();
    end
    addr_ok = 1;
    tick();
    addr_ok = 0; data_ok = 1; rdata = 32'h1111_1111;
    settle();
    chk("bw_data_stall", 32'(d_stall), 32'd1);
    tick();
    data_ok = 0; longest_stall = 1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("ls_stall", 32'(d_stall), 32'd0);
      chk("ls_req", 32'(req), 32'd0);
      chk("ls_rdata", data_sram_rdata, 32'hDEAD_BEEF);
      tick();
    end
    data_sram_en = 0; longest_stall = 0;
    tick();

    // Cancelled access never starts
    data_sram_en = 1; data_sram_wen = 4'b0000; data_sram_addr = 32'h300; except_cancel = 1;
    settle();
    chk("cn_stall", 32'(d_stall), 32'd0);
    tick();
    settle();
    chk("cn_req", 32'(req), 32'd0);
    chk("cn_stall2", 32'(d_stall), 32'd0);
    // Cancel raised mid-access does not abort it
    except_cancel = 0;
    tick();
    addr_ok = 1;
    tick();
    addr_ok = 0; except_cancel = 1;
    settle();
    chk("cd_stall", 32'(d_stall), 32'd1);
    data_ok = 1; rdata = 32'hCAFE_F00D;
    tick();
    data_ok = 0; except_cancel = 0; data_sram_en = 0;
    settle();
    chk("cd_rdata", data_sram_rdata, 32'hCAFE_F00D);
    chk("cd_stall_done", 32'(d_stall), 32'd0);
    tick();

    // Reset while in DATA, then a stray data_ok
    data_sram_en = 1; data_sram_wen = 4'b0000; data_sram_addr = 32'h400;
    tick();
    addr_ok = 1;
    tick();
    addr_ok = 0; rst = 0;
    settle();
    chk("mr_stall_in_rst", 32'(d_stall), 32'd0);
    tick();
    data_sram_en = 0;
    settle();
    chk("mr_rdata", data_sram_rdata, 32'd0);
    chk("mr_req", 32'(req), 32'd0);
    chk("mr_addr", addr, 32'd0);
    rst = 1; data_ok = 1; rdata = 32'h55AA_55AA;
    tick();
    data_ok = 0; rdata = 0;
    settle();
    chk("mr_stray_rdata", data_sram_rdata, 32'd0);
    chk("mr_stray_stall", 32'(d_stall), 32'd0);
    tick();

    // Halfword strobes
    for (int k = 0; k < 2; k++) begin
      data_sram_en = 1;
      data_sram_wen = (k == 0) ? 4'b1100 : 4'b0011;
      data_sram_addr = (k == 0) ? 32'h40 : 32'h43;
      tick();
      settle();
      chk("hw_size", 32'(size), 32'd1);
      chk("hw_addr", addr, (k == 0) ? 32'h42 : 32'h40);
      chk("hw_wr", 32'(wr), 32'd1);
      addr_ok = 1;
      tick();
      addr_ok = 0; data_ok = 1;
      tick();
      data_ok = 0; data_sram_en = 0;
      tick();
    end

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst             = ($urandom_range(0, 99) != 0);
      data_sram_en    = ($urandom_range(0, 1) == 1);
      data_sram_wen   = 4'($urandom);
      data_sram_addr  = $urandom;
      data_sram_wdata = $urandom;
      except_cancel   = ($urandom_range(0, 4) == 0);
      longest_stall   = ($urandom_range(0, 4) < 2);
      addr_ok         = ($urandom_range(0, 4) < 2);
      data_ok         = ($urandom_range(0, 4) < 2);
      rdata           = $urandom;
      tick();
    end
    quietInputs();
    rst = 1;
    tick(); tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
